uart_tx_sched: RTL and testbench

Round-robin scheduler that shares the single UART transmitter between four byte sources. It accepts per-requester byte requests, selects one requester, and presents its byte to the transmitter's `tx_data`/`ready` inputs with the required setup cycle. It then tracks the transmitter's `tdre` through the stop bit and returns a one-cycle acknowledge to the served requester. It sits between the byte producers and the UART transmitter and is the only block allowed to drive the transmitter's `ready`.

---
 rtl/uart_tx_sched_if.sv | 37 +++
 rtl/uart_tx_sched.sv | 144 ++++++++++++++
 tb/tb_uart_tx_sched.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// Bundle between byte producers / UART transmitter and the round-robin scheduler.
// The scheduler uses the slave modport; the producer/transmitter side uses master.
interface uart_tx_sched_if;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_tdre;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;

    modport master (
        output req,
        output req_data,
        output tx_tdre,
        input  ack,
        input  tx_ready,
        input  tx_data,
        input  busy,
        input  grant_id,
        input  timeout_err
    );

    modport slave (
        input  req,
        input  req_data,
        input  tx_tdre,
        output ack,
        output tx_ready,
        output tx_data,
        output busy,
        output grant_id,
        output timeout_err
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between four byte sources.
// Every output comes straight from a register; the watchdog abandons stuck frames.
module uart_tx_sched #(
    parameter int unsigned     TO_W    = 20,
    parameter logic [TO_W-1:0] TIMEOUT = 20'd100000
) (
    input logic            clk,
    input logic            clr,
    uart_tx_sched_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StWaitDone,
        StWaitIdle,
        StAck
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_last_grant;
    logic [1:0]      r_grant_id;
    logic [7:0]      r_tx_data;
    logic            r_tx_ready;
    logic [3:0]      r_ack;
    logic            r_busy;
    logic            r_timeout_err;
    logic [TO_W-1:0] r_wd;
    logic [TO_W-1:0] w_wd_nxt;
    logic [TO_W-1:0] w_wd_inc;
    logic            w_wd_hit;
    logic            w_err_set;
    logic            w_load;
    logic            w_pick_valid;
    logic [1:0]      w_pick_id;

    // Scan starts one past the last served requester so no one is served twice in a row
    // while others wait.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_id    = r_last_grant;
        for (int k = 1; k <= 4; k++) begin
            if (!w_pick_valid && bus.req[r_last_grant + 2'(k)]) begin
                w_pick_valid = 1'b1;
                w_pick_id    = r_last_grant + 2'(k);
            end
        end
    end

    // Saturating watchdog: the hit test looks at the value being written.
    assign w_wd_inc = (r_wd == TIMEOUT) ? r_wd : r_wd + 1'b1;
    assign w_wd_hit = (w_wd_inc == TIMEOUT);

    always_comb begin
        w_state_nxt = r_state;
        w_wd_nxt    = r_wd;
        w_err_set   = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_pick_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = StLoad;
                end
            end
            StLoad: begin
                w_state_nxt = StStart;
            end
            StStart: begin
                w_wd_nxt    = '0;
                w_state_nxt = StWaitDone;
            end
            StWaitDone: begin
                if (bus.tx_tdre) begin
                    w_wd_nxt    = '0;
                    w_state_nxt = StWaitIdle;
                end else begin
                    w_wd_nxt = w_wd_inc;
                    if (w_wd_hit) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = StAck;
                    end
                end
            end
            StWaitIdle: begin
                if (!bus.tx_tdre) begin
                    w_state_nxt = StAck;
                end else begin
                    w_wd_nxt = w_wd_inc;
                    if (w_wd_hit) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = StAck;
                    end
                end
            end
            StAck: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state       <= StIdle;
            r_last_grant  <= 2'd3;
            r_grant_id    <= 2'd0;
            r_tx_data     <= 8'h00;
            r_tx_ready    <= 1'b0;
            r_ack         <= 4'b0000;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_wd          <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wd       <= w_wd_nxt;
            r_tx_ready <= (w_state_nxt == StStart);
            r_busy     <= (w_state_nxt != StIdle);
            r_ack      <= (w_state_nxt == StAck) ? (4'b0001 << r_grant_id) : 4'b0000;
            if (w_load) begin
                r_grant_id <= w_pick_id;
                r_tx_data  <= bus.req_data[{w_pick_id, 3'b000} +: 8];
            end
            if (r_state == StAck) begin
                r_last_grant <= r_grant_id;
            end
            if (w_err_set) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign bus.ack         = r_ack;
    assign bus.tx_ready    = r_tx_ready;
    assign bus.tx_data     = r_tx_data;
    assign bus.busy        = r_busy;
    assign bus.grant_id    = r_grant_id;
    assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: drives requests and the transmitter tdre by hand
// and compares every observed output against hand-computed values.
module tb_uart_tx_sched;

    logic clk;
    logic clr;
    int   checks;
    int   failures;

    uart_tx_sched_if bus ();

    uart_tx_sched #(
        .TO_W    (20),
        .TIMEOUT (20'd100)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        clr         = 1'b1;
        bus.req     = 4'b0000;
        bus.tx_tdre = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(bus.tx_ready), 32'd0);
        check("rst_data", 32'(bus.tx_data), 32'h00);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_gid", 32'(bus.grant_id), 32'd0);
        check("rst_err", 32'(bus.timeout_err), 32'd0);
        clr = 1'b0;
    endtask

    // Entered at a negedge in IDLE with req already set; returns at the ack negedge.
    task automatic frame(input logic [1:0] id, input logic [7:0] byte_v,
                         input logic [3:0] req_wd);
        tick();
        check("load_data", 32'(bus.tx_data), 32'(byte_v));
        check("load_gid", 32'(bus.grant_id), 32'(id));
        check("load_ready", 32'(bus.tx_ready), 32'd0);
        tick();
        check("start_ready", 32'(bus.tx_ready), 32'd1);
        tick();
        check("wd_ready", 32'(bus.tx_ready), 32'd0);
        check("wd_busy", 32'(bus.busy), 32'd1);
        bus.req = req_wd;
        tick();
        tick();
        bus.tx_tdre = 1'b1;
        tick();
        check("wi_ack", 32'(bus.ack), 32'd0);
        tick();
        bus.tx_tdre = 1'b0;
        tick();
        check("ack", 32'(bus.ack), 32'(4'b0001 << id));
        check("ack_data", 32'(bus.tx_data), 32'(byte_v));
    endtask

    initial begin
        int n;
        checks       = 0;
        failures     = 0;
        clr          = 1'b1;
        bus.req      = 4'b0000;
        bus.req_data = 32'h0;
        bus.tx_tdre  = 1'b0;

        // Single byte
        reset_dut();
        bus.req_data = 32'h0000_0055;
        bus.req      = 4'b0001;
        frame(2'd0, 8'h55, 4'b0001);
        bus.req = 4'b0000;
        tick();
        check("t1_idle_busy", 32'(bus.busy), 32'd0);
        check("t1_idle_ack", 32'(bus.ack), 32'd0);

        // Full contention from reset priority
        reset_dut();
        bus.req_data = 32'hA3A2_A1A0;
        bus.req      = 4'b1111;
        frame(2'd0, 8'hA0, 4'b1111);
        bus.req = 4'b1110;
        tick();
        check("t2_gap_busy", 32'(bus.busy), 32'd0);
        frame(2'd1, 8'hA1, 4'b1110);
        bus.req = 4'b1100;
        tick();
        frame(2'd2, 8'hA2, 4'b1100);
        bus.req = 4'b1000;
        tick();
        frame(2'd3, 8'hA3, 4'b1000);
        bus.req = 4'b0000;
        tick();
        check("t2_end_busy", 32'(bus.busy), 32'd0);

        // Fairness: requester 0 streams, requester 2 holds
        bus.req_data = 32'h0020_0010;
        bus.req      = 4'b0101;
        frame(2'd0, 8'h10, 4'b0101);
        bus.req_data = 32'h0020_0011;
        tick();
        frame(2'd2, 8'h20, 4'b0101);
        bus.req_data = 32'h0021_0011;
        tick();
        frame(2'd0, 8'h11, 4'b0101);
        bus.req = 4'b0100;
        tick();
        frame(2'd2, 8'h21, 4'b0100);
        bus.req = 4'b0000;
        tick();

        // Watchdog: tdre never rises
        bus.req_data = 32'h0000_7700;
        bus.req      = 4'b0010;
        tick();
        check("t4_gid", 32'(bus.grant_id), 32'd1);
        tick();
        check("t4_start", 32'(bus.tx_ready), 32'd1);
        check("t4_err_pre", 32'(bus.timeout_err), 32'd0);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n++;
            if (bus.ack != 4'b0000) break;
        end
        check("t4_wait_cycles", 32'(n), 32'd101);
        check("t4_ack", 32'(bus.ack), 32'b0010);
        check("t4_err", 32'(bus.timeout_err), 32'd1);
        bus.req = 4'b0000;
        tick();
        check("t4_idle_busy", 32'(bus.busy), 32'd0);
        bus.req_data = 32'h0000_0033;
        bus.req      = 4'b0001;
        frame(2'd0, 8'h33, 4'b0001);
        bus.req = 4'b0000;
        check("t4_err_sticky", 32'(bus.timeout_err), 32'd1);
        tick();

        // Reset mid-frame in WAIT_IDLE
        reset_dut();
        bus.req_data = 32'h0000_0044;
        bus.req      = 4'b0001;
        tick();
        tick();
        tick();
        bus.tx_tdre = 1'b1;
        tick();
        check("t5_wi_busy", 32'(bus.busy), 32'd1);
        clr         = 1'b1;
        bus.tx_tdre = 1'b0;
        tick();
        check("t5_clr_busy", 32'(bus.busy), 32'd0);
        check("t5_clr_ack", 32'(bus.ack), 32'd0);
        check("t5_clr_data", 32'(bus.tx_data), 32'h00);
        check("t5_clr_gid", 32'(bus.grant_id), 32'd0);
        check("t5_clr_ready", 32'(bus.tx_ready), 32'd0);
        clr          = 1'b0;
        bus.req_data = 32'hC300_0000;
        bus.req      = 4'b1000;
        frame(2'd3, 8'hC3, 4'b1000);
        bus.req = 4'b0000;
        tick();
        check("t5_end_busy", 32'(bus.busy), 32'd0);

        // Withdrawal during WAIT_DONE
        bus.req_data = 32'h0000_5A00;
        bus.req      = 4'b0010;
        frame(2'd1, 8'h5A, 4'b0000);
        tick();
        tick();
        check("t6_no_regrant", 32'(bus.busy), 32'd0);
        check("t6_no_ack", 32'(bus.ack), 32'd0);
        tick();
        check("t6_data_hold", 32'(bus.tx_data), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
